mem_port_arbiter: RTL and testbench

- Sits directly upstream of the 16-bit single-port data/instruction memory.
- Accepts requests from two ports: the instruction-fetch port (IF) and the data port (DM, load/store).
- Arbitrates between the ports with round-robin priority.
- Sequences each access onto the memory's ON/W/ADDR/DATA_IN controls and captures DATA_OUT for reads.
- Returns a one-cycle ACK to the port that was served.

---
 rtl/mem_port_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Round-robin arbiter between the instruction-fetch port (IF) and the data
// port (DM) in front of a single-port word memory. Each granted request is
// sequenced as IDLE -> ACCESS -> RESP (or IDLE -> RESP for an out-of-range
// address) and answered with a one-cycle ACK to the served port.
//
// Ports
//   CLK, RST                  clock, synchronous active-high reset
//   IF_REQ/IF_ADDR            fetch request (read only), held until IF_ACK
//   IF_ACK/IF_DATA/IF_ERR     fetch response; IF_DATA held until next IF_ACK
//   DM_REQ/DM_WE/DM_ADDR/
//   DM_WDATA                  data request (load/store), held until DM_ACK
//   DM_ACK/DM_RDATA/DM_ERR    data response; DM_RDATA held until next DM_ACK
//   MEM_ON/MEM_W/MEM_ADDR/
//   MEM_DIN                   memory controls, active only during ACCESS
//   MEM_DOUT                  memory read data, sampled at the end of ACCESS
module mem_port_arbiter #(
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned DEPTH     = 16
) (
    input  logic                 CLK,
    input  logic                 RST,

    input  logic                 IF_REQ,
    input  logic [WORD_SIZE-1:0] IF_ADDR,
    output logic                 IF_ACK,
    output logic [WORD_SIZE-1:0] IF_DATA,
    output logic                 IF_ERR,

    input  logic                 DM_REQ,
    input  logic                 DM_WE,
    input  logic [WORD_SIZE-1:0] DM_ADDR,
    input  logic [WORD_SIZE-1:0] DM_WDATA,
    output logic                 DM_ACK,
    output logic [WORD_SIZE-1:0] DM_RDATA,
    output logic                 DM_ERR,

    output logic                 MEM_ON,
    output logic                 MEM_W,
    output logic [WORD_SIZE-1:0] MEM_ADDR,
    output logic [WORD_SIZE-1:0] MEM_DIN,
    input  logic [WORD_SIZE-1:0] MEM_DOUT
);

    localparam logic [WORD_SIZE-1:0] DEPTH_W = WORD_SIZE'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic                  last_dm_q, last_dm_d;
    logic                  gnt_dm_q, gnt_dm_d;
    logic                  we_q, we_d;

    logic                  mem_on_q, mem_on_d;
    logic                  mem_w_q, mem_w_d;
    logic [WORD_SIZE-1:0]  mem_addr_q, mem_addr_d;
    logic [WORD_SIZE-1:0]  mem_din_q, mem_din_d;

    logic                  if_ack_q, if_ack_d;
    logic                  if_err_q, if_err_d;
    logic [WORD_SIZE-1:0]  if_data_q, if_data_d;
    logic                  dm_ack_q, dm_ack_d;
    logic                  dm_err_q, dm_err_d;
    logic [WORD_SIZE-1:0]  dm_rdata_q, dm_rdata_d;

    // Arbitration view of the request inputs, only consumed in IDLE
    logic                  pick_dm_c;
    logic [WORD_SIZE-1:0]  sel_addr_c;
    logic                  sel_we_c;
    logic                  sel_oor_c;

    // DM wins unless IF is also requesting and DM was served last
    always_comb begin
        pick_dm_c  = DM_REQ && (!IF_REQ || !last_dm_q);
        sel_addr_c = pick_dm_c ? DM_ADDR : IF_ADDR;
        sel_we_c   = pick_dm_c && DM_WE;
        sel_oor_c  = (sel_addr_c >= DEPTH_W);
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        last_dm_d  = last_dm_q;
        gnt_dm_d   = gnt_dm_q;
        we_d       = we_q;
        mem_on_d   = 1'b0;
        mem_w_d    = 1'b0;
        mem_addr_d = '0;
        mem_din_d  = '0;
        if_ack_d   = 1'b0;
        if_err_d   = 1'b0;
        if_data_d  = if_data_q;
        dm_ack_d   = 1'b0;
        dm_err_d   = 1'b0;
        dm_rdata_d = dm_rdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (IF_REQ || DM_REQ) begin
                    gnt_dm_d  = pick_dm_c;
                    last_dm_d = pick_dm_c;
                    we_d      = sel_we_c;
                    if (sel_oor_c) begin
                        // Out-of-range: answer straight away, memory untouched
                        state_d = ST_RESP;
                        if (pick_dm_c) begin
                            dm_ack_d   = 1'b1;
                            dm_err_d   = 1'b1;
                            dm_rdata_d = '0;
                        end else begin
                            if_ack_d  = 1'b1;
                            if_err_d  = 1'b1;
                            if_data_d = '0;
                        end
                    end else begin
                        state_d    = ST_ACCESS;
                        mem_on_d   = 1'b1;
                        mem_w_d    = sel_we_c;
                        mem_addr_d = sel_addr_c;
                        mem_din_d  = sel_we_c ? DM_WDATA : '0;
                    end
                end
            end

            ST_ACCESS: begin
                // Memory read data is valid on the edge that ends ACCESS
                state_d = ST_RESP;
                if (gnt_dm_q) begin
                    dm_ack_d   = 1'b1;
                    dm_rdata_d = we_q ? '0 : MEM_DOUT;
                end else begin
                    if_ack_d  = 1'b1;
                    if_data_d = MEM_DOUT;
                end
            end

            ST_RESP: begin
                // Turnaround cycle: memory disabled while MEM_DOUT settles
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            last_dm_q  <= 1'b0;
            gnt_dm_q   <= 1'b0;
            we_q       <= 1'b0;
            mem_on_q   <= 1'b0;
            mem_w_q    <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            if_ack_q   <= 1'b0;
            if_err_q   <= 1'b0;
            if_data_q  <= '0;
            dm_ack_q   <= 1'b0;
            dm_err_q   <= 1'b0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            last_dm_q  <= last_dm_d;
            gnt_dm_q   <= gnt_dm_d;
            we_q       <= we_d;
            mem_on_q   <= mem_on_d;
            mem_w_q    <= mem_w_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            if_ack_q   <= if_ack_d;
            if_err_q   <= if_err_d;
            if_data_q  <= if_data_d;
            dm_ack_q   <= dm_ack_d;
            dm_err_q   <= dm_err_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    assign MEM_ON   = mem_on_q;
    assign MEM_W    = mem_w_q;
    assign MEM_ADDR = mem_addr_q;
    assign MEM_DIN  = mem_din_q;
    assign IF_ACK   = if_ack_q;
    assign IF_ERR   = if_err_q;
    assign IF_DATA  = if_data_q;
    assign DM_ACK   = dm_ack_q;
    assign DM_ERR   = dm_err_q;
    assign DM_RDATA = dm_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural 16-word memory on the MEM_* port,
// a transaction-level schedule model predicting every output cycle by cycle,
// directed scenarios followed by randomized IF/DM request traffic.
module tb_mem_port_arbiter;

    localparam int unsigned W     = 16;
    localparam int unsigned DEPTH = 16;

    logic         CLK;
    logic         RST;
    logic         IF_REQ;
    logic [W-1:0] IF_ADDR;
    logic         IF_ACK;
    logic [W-1:0] IF_DATA;
    logic         IF_ERR;
    logic         DM_REQ;
    logic         DM_WE;
    logic [W-1:0] DM_ADDR;
    logic [W-1:0] DM_WDATA;
    logic         DM_ACK;
    logic [W-1:0] DM_RDATA;
    logic         DM_ERR;
    logic         MEM_ON;
    logic         MEM_W;
    logic [W-1:0] MEM_ADDR;
    logic [W-1:0] MEM_DIN;
    logic [W-1:0] MEM_DOUT;

    mem_port_arbiter #(.WORD_SIZE(W), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST),
        .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_ACK(IF_ACK),
        .IF_DATA(IF_DATA), .IF_ERR(IF_ERR),
        .DM_REQ(DM_REQ), .DM_WE(DM_WE), .DM_ADDR(DM_ADDR),
        .DM_WDATA(DM_WDATA), .DM_ACK(DM_ACK), .DM_RDATA(DM_RDATA),
        .DM_ERR(DM_ERR),
        .MEM_ON(MEM_ON), .MEM_W(MEM_W), .MEM_ADDR(MEM_ADDR),
        .MEM_DIN(MEM_DIN), .MEM_DOUT(MEM_DOUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- external memory (no reset) ----------------
    logic         tb_init;
    logic [W-1:0] mem_arr [DEPTH];
    logic [W-1:0] junk;

    always @(posedge CLK) begin
        if (tb_init) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_arr[i] <= W'(i * 16'h1357 + 16'h0A0F);
        end else if (MEM_ON && MEM_W) begin
            mem_arr[MEM_ADDR[3:0]] <= MEM_DIN;
        end
    end

    // Bus noise stands in for the undriven (high-Z) read bus
    always @(negedge CLK) junk <= W'($urandom);
    assign MEM_DOUT = (MEM_ON && !MEM_W) ? mem_arr[MEM_ADDR[3:0]] : junk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic         on;
        logic         w;
        logic [W-1:0] addr;
        logic [W-1:0] din;
        logic         if_ack;
        logic         if_err;
        logic         dm_ack;
        logic         dm_err;
        logic [W-1:0] data;
    } exp_t;

    exp_t         sched [int];
    exp_t         cur;
    exp_t         nxt;
    logic [W-1:0] ref_mem [DEPTH];
    logic [W-1:0] exp_if_data;
    logic [W-1:0] exp_dm_data;
    int           edge_n      = 0;
    int           next_decide = 0;
    bit           last_dm     = 1'b0;
    bit           g_dm;
    bit           g_we;
    logic [W-1:0] g_addr;
    logic [W-1:0] g_wd;

    // Each granted request books its memory cycle and its ACK cycle ahead;
    // the arbiter is free again 3 edges (legal) or 2 edges (error) later.
    always @(posedge CLK) begin
        edge_n++;
        if (tb_init)
            for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = W'(i * 16'h1357 + 16'h0A0F);
        if (RST) begin
            sched.delete();
            last_dm     = 1'b0;
            next_decide = edge_n + 1;
            exp_if_data = '0;
            exp_dm_data = '0;
            cur         = '0;
        end else begin
            if (edge_n >= next_decide && (IF_REQ || DM_REQ)) begin
                g_dm    = DM_REQ && !(IF_REQ && last_dm);
                last_dm = g_dm;
                g_addr  = g_dm ? DM_ADDR : IF_ADDR;
                g_we    = g_dm && DM_WE;
                g_wd    = DM_WDATA;
                nxt     = '0;
                if (int'(g_addr) >= int'(DEPTH)) begin
                    if (g_dm) begin nxt.dm_ack = 1'b1; nxt.dm_err = 1'b1; end
                    else      begin nxt.if_ack = 1'b1; nxt.if_err = 1'b1; end
                    sched[edge_n] = nxt;
                    next_decide   = edge_n + 2;
                end else begin
                    nxt.on   = 1'b1;
                    nxt.w    = g_we;
                    nxt.addr = g_addr;
                    nxt.din  = g_we ? g_wd : '0;
                    sched[edge_n] = nxt;
                    nxt = '0;
                    if (g_dm) nxt.dm_ack = 1'b1; else nxt.if_ack = 1'b1;
                    if (g_we) begin
                        ref_mem[g_addr[3:0]] = g_wd;
                        nxt.data = '0;
                    end else begin
                        nxt.data = ref_mem[g_addr[3:0]];
                    end
                    sched[edge_n + 1] = nxt;
                    next_decide = edge_n + 3;
                end
            end
            cur = sched.exists(edge_n) ? sched[edge_n] : '0;
            sched.delete(edge_n);
            if (cur.if_ack) exp_if_data = cur.data;
            if (cur.dm_ack) exp_dm_data = cur.data;
        end
    end

    // Every cycle: all DUT outputs against the model
    always @(negedge CLK) begin
        if (edge_n > 0) begin
            chk("mem_ctl", 64'({MEM_ON, MEM_W, MEM_ADDR, MEM_DIN}),
                64'({cur.on, cur.w, cur.addr, cur.din}));
            chk("ack_err", 64'({IF_ACK, IF_ERR, DM_ACK, DM_ERR}),
                64'({cur.if_ack, cur.if_err, cur.dm_ack, cur.dm_err}));
            chk("if_data", 64'(IF_DATA), 64'(exp_if_data));
            chk("dm_rdata", 64'(DM_RDATA), 64'(exp_dm_data));
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [W-1:0] rand_addr();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return W'(DEPTH);
        if (r == 1) return 16'hFFFF;
        if (r == 2) return W'(DEPTH - 1);
        return W'($urandom_range(0, DEPTH - 1));
    endfunction

    task automatic step_agents();
        if (IF_ACK) IF_REQ = 1'b0;
        else if (!IF_REQ && $urandom_range(0, 2) == 0) begin
            IF_REQ  = 1'b1;
            IF_ADDR = rand_addr();
        end
        if (DM_ACK) DM_REQ = 1'b0;
        else if (!DM_REQ && $urandom_range(0, 2) == 0) begin
            DM_REQ   = 1'b1;
            DM_WE    = 1'($urandom_range(0, 1));
            DM_ADDR  = rand_addr();
            DM_WDATA = W'($urandom);
        end
    endtask

    // Bounded wait for the chosen port's ACK; lat = -1 on timeout
    task automatic wait_ack(input bit dm, output int lat, output bit saw_on);
        lat    = -1;
        saw_on = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge CLK);
            if (MEM_ON) saw_on = 1'b1;
            if (dm ? DM_ACK : IF_ACK) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic dm_req(input bit we, input logic [W-1:0] a, input logic [W-1:0] d);
        DM_REQ = 1'b1; DM_WE = we; DM_ADDR = a; DM_WDATA = d;
    endtask

    int lat;
    bit saw_on;
    int cnt;

    initial begin
        RST = 1'b1; tb_init = 1'b1;
        IF_REQ = 1'b0; IF_ADDR = '0;
        DM_REQ = 1'b0; DM_WE = 1'b0; DM_ADDR = '0; DM_WDATA = '0;
        @(negedge CLK);
        tb_init = 1'b0;
        @(negedge CLK);
        chk("reset_outs", 64'({IF_ACK, IF_ERR, DM_ACK, DM_ERR, MEM_ON, MEM_W, MEM_ADDR}), 64'd0);
        RST = 1'b0;

        // Store 0xBEEF at 3, then load it back
        dm_req(1'b1, 16'd3, 16'hBEEF);
        wait_ack(1'b1, lat, saw_on);
        chk("st_lat", 64'(lat), 64'd2);
        chk("st_err", 64'(DM_ERR), 64'd0);
        DM_REQ = 1'b0;
        @(negedge CLK);
        dm_req(1'b0, 16'd3, 16'h0);
        wait_ack(1'b1, lat, saw_on);
        chk("ld_lat", 64'(lat), 64'd2);
        chk("ld_data", 64'(DM_RDATA), 64'hBEEF);
        DM_REQ = 1'b0;
        @(negedge CLK);

        // Fetch the same word through IF
        IF_REQ = 1'b1; IF_ADDR = 16'd3;
        wait_ack(1'b0, lat, saw_on);
        chk("if_lat", 64'(lat), 64'd2);
        chk("if_data_beef", 64'(IF_DATA), 64'hBEEF);
        chk("if_no_dm_ack", 64'(DM_ACK), 64'd0);
        IF_REQ = 1'b0;
        @(negedge CLK);

        // DEPTH boundary
        dm_req(1'b0, W'(DEPTH - 1), 16'h0);
        wait_ack(1'b1, lat, saw_on);
        chk("last_ok_lat", 64'(lat), 64'd2);
        chk("last_ok_err", 64'(DM_ERR), 64'd0);
        DM_REQ = 1'b0;
        @(negedge CLK);
        dm_req(1'b0, W'(DEPTH), 16'h0);
        wait_ack(1'b1, lat, saw_on);
        chk("oor_lat", 64'(lat), 64'd1);
        chk("oor_err", 64'(DM_ERR), 64'd1);
        chk("oor_rdata", 64'(DM_RDATA), 64'd0);
        chk("oor_mem_off", 64'(saw_on), 64'd0);
        DM_REQ = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        IF_REQ = 1'b1; IF_ADDR = 16'hFFFF;
        wait_ack(1'b0, lat, saw_on);
        chk("ffff_err", 64'({IF_ERR, IF_DATA}), 64'h1_0000);
        IF_REQ = 1'b0;
        @(negedge CLK);

        // Reset during the ACCESS of a store: no ACK, but the store commits
        dm_req(1'b1, 16'd5, 16'h1234);
        cnt = 0;
        for (int i = 0; i < 6 && !(MEM_ON && MEM_W); i++) begin
            @(negedge CLK);
            cnt++;
        end
        chk("rst_st_access", 64'({MEM_ON, MEM_W}), 64'd3);
        RST = 1'b1; DM_REQ = 1'b0;
        @(negedge CLK);
        chk("rst_no_ack", 64'(DM_ACK), 64'd0);
        chk("rst_clear", 64'({IF_ACK, DM_ACK, MEM_ON, MEM_W, MEM_ADDR, MEM_DIN, DM_RDATA}), 64'd0);
        RST = 1'b0;
        dm_req(1'b0, 16'd5, 16'h0);
        wait_ack(1'b1, lat, saw_on);
        chk("rst_commit", 64'(DM_RDATA), 64'h1234);

        // REQ held past its ACK is resampled in IDLE as a new request
        cnt = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge CLK);
            if (DM_ACK) cnt++;
            if (i == 2) DM_REQ = 1'b0;
        end
        chk("resample", 64'(cnt), 64'd1);

        // Both ports held from reset: DM, IF, DM, IF, three cycles apart
        RST = 1'b1;
        @(negedge CLK);
        IF_REQ = 1'b1; IF_ADDR = 16'd3;
        dm_req(1'b0, 16'd4, 16'h0);
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge CLK);
            chk("rr_order", 64'({IF_ACK, DM_ACK}),
                (i % 3 == 2) ? (((i / 3) % 2 == 0) ? 64'd1 : 64'd2) : 64'd0);
        end
        IF_REQ = 1'b0; DM_REQ = 1'b0;
        repeat (3) @(negedge CLK);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            RST = ($urandom_range(0, 299) == 0);
            step_agents();
        end
        RST = 1'b0; IF_REQ = 1'b0; DM_REQ = 1'b0;
        repeat (5) @(negedge CLK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
